// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_BITS LSB first, optional parity, 1 or 2 stop bits.
// Define UART_TX_CTS_EN to gate acceptance on cts and drive rts while idle; default build ignores cts.
module uart_tx_cfg #(
  parameter int FREQUENCY = 10000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 cts,
  output logic                 rts,
  output logic                 tx_serial,
  output logic                 tx_active,
  output logic                 tx_done
);
  localparam int CLKS_PER_BIT = FREQUENCY / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic                 stop_reg, stop_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 parity_reg, parity_next;
  logic                 serial_reg, serial_next;
  logic                 done_reg, done_next;
  logic                 idle;
  logic                 accept;
  logic                 bit_end;
  logic                 stop_last;

  // Ready is forced low while reset is held even though the state already reads IDLE.
  assign idle = (state_reg == IDLE) && !reset;

`ifdef UART_TX_CTS_EN
  assign tx_ready = idle && cts;
  assign rts      = idle;
`else
  logic cts_unused;
  assign cts_unused = cts;
  assign tx_ready   = idle;
  assign rts        = 1'b0;
`endif

  assign accept    = tx_valid && tx_ready;
  assign bit_end   = (cnt_reg == CNT_LAST);
  assign stop_last = (STOP_BITS == 2) ? stop_reg : 1'b1;

  assign tx_serial = serial_reg;
  assign tx_active = (state_reg != IDLE);
  assign tx_done   = done_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      idx_reg    <= '0;
      stop_reg   <= 1'b0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      serial_reg <= 1'b1;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      idx_reg    <= idx_next;
      stop_reg   <= stop_next;
      shift_reg  <= shift_next;
      parity_reg <= parity_next;
      serial_reg <= serial_next;
      done_reg   <= done_next;
    end
  end

  // serial_next always carries the level of the bit period starting next cycle,
  // so the line itself comes straight from a flop.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    idx_next    = idx_reg;
    stop_next   = stop_reg;
    shift_next  = shift_reg;
    parity_next = parity_reg;
    serial_next = serial_reg;
    done_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        serial_next = 1'b1;
        if (accept) begin
          shift_next  = tx_data;
          parity_next = (PARITY == 1) ? ~^tx_data : ^tx_data;
          cnt_next    = '0;
          serial_next = 1'b0;
          state_next  = START;
        end
      end

      START: begin
        if (bit_end) begin
          cnt_next    = '0;
          idx_next    = '0;
          serial_next = shift_reg[0];
          state_next  = DATA;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_next = '0;
          if (idx_reg == IDX_LAST) begin
            if (PARITY != 0) begin
              serial_next = parity_reg;
              state_next  = PAR;
            end else begin
              serial_next = 1'b1;
              stop_next   = 1'b0;
              state_next  = STOP;
            end
          end else begin
            idx_next    = idx_reg + IDX_W'(1);
            shift_next  = shift_reg >> 1;
            serial_next = shift_reg[1];
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      PAR: begin
        if (bit_end) begin
          cnt_next    = '0;
          stop_next   = 1'b0;
          serial_next = 1'b1;
          state_next  = STOP;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      STOP: begin
        serial_next = 1'b1;
        if (bit_end) begin
          cnt_next = '0;
          if (stop_last) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            stop_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      default: begin
        cnt_next    = '0;
        idx_next    = '0;
        stop_next   = 1'b0;
        serial_next = 1'b1;
        state_next  = IDLE;
      end
    endcase
  end

endmodule
